store_buffer: RTL and testbench

Posted-write store buffer between the store-data formatter and data memory. It accepts size-formatted store data (byte, halfword or word), aligns it onto the correct byte lanes and computes byte enables. Entries are queued in a small FIFO and drained to the data-memory write port through a req/ack handshake, so the pipeline does not stall on memory latency unless the buffer is full.

---
 rtl/store_buffer.sv | 115 +++++++++++
 tb/tb_store_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: lane-aligns byte/half/word stores and queues them for a req/ack memory port.
// Optional STORE_BUF_ALIGN_CHK_EN rejects misaligned half/word stores and pulses misalign.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_data,
    input  logic                     in_sb,
    input  logic                     in_sh,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]  a;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        accept, push, pop, bad_align;

    assign a = in_addr[1:0];

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = in_data;
        if (in_sb) begin
            be_d    = 4'b0001 << a;
            wdata_d = {4{in_data[7:0]}};
        end else if (in_sh) begin
            be_d    = a[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{in_data[15:0]}};
        end
    end

`ifdef STORE_BUF_ALIGN_CHK_EN
    logic misalign_q;
    // Rejected stores still complete the handshake so the pipeline never retries them.
    assign bad_align = in_sb ? 1'b0 : (in_sh ? a[0] : (a != 2'b00));
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= accept && bad_align;
    end
    assign misalign = misalign_q;
`else
    assign bad_align = 1'b0;
    assign misalign  = 1'b0;
`endif

    assign in_ready = (count_q != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && !bad_align;
    assign pop      = mem_req && mem_ack;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is reset so the head reads zero until the first store lands.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                addr_q[gi]  <= '0;
                wdata_q[gi] <= '0;
                be_q[gi]    <= '0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
                addr_q[gi]  <= {in_addr[31:2], 2'b00};
                wdata_q[gi] <= wdata_d;
                be_q[gi]    <= be_d;
            end
        end
    end

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_req   = !empty;
    assign mem_addr  = addr_q[rd_ptr_q];
    assign mem_wdata = wdata_q[rd_ptr_q];
    assign mem_be    = mem_req ? be_q[rd_ptr_q] : 4'b0000;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: lane-mapping table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_BUF_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_data;
    logic        in_sb, in_sh;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_sb(in_sb), .in_sh(in_sh),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .empty(empty), .count(count), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        sb;
        logic        sh;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ad, input logic [31:0] d,
                         input logic sb, input logic sh, input logic ack);
        in_valid = v; in_addr = ad; in_data = d; in_sb = sb; in_sh = sh; mem_ack = ack;
    endtask

    // Reference lane formatting from size arithmetic: access of sz bytes at the sz-aligned offset.
    function automatic entry_t fmt(input logic [31:0] ad, input logic [31:0] d,
                                   input logic sb, input logic sh);
        entry_t e;
        int sz, off;
        sz  = sb ? 1 : (sh ? 2 : 4);
        off = int'(ad[1:0]);
        off = off - (off % sz);
        e.addr = ad & 32'hFFFF_FFFC;
        e.be   = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
        return e;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] ad, input logic sb, input logic sh);
        int sz;
        sz = sb ? 1 : (sh ? 2 : 4);
        return (int'(ad[1:0]) % sz) != 0;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    vec_t   vecs [6];
    entry_t q[$];
    entry_t e;
    logic [31:0] fill_addr [5];
    int     accepted;

    initial begin
        vecs[0] = '{32'h0000_0103, 32'h0000_00A5, 1, 0, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000};
        vecs[1] = '{32'h0000_0202, 32'h0000_BEEF, 0, 1, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100};
        vecs[2] = '{32'h0000_0201, 32'h1234_5677, 1, 1, 32'h0000_0200, 32'h7777_7777, 4'b0010};
        vecs[3] = '{32'h0000_0400, 32'hDEAD_BEEF, 0, 0, 32'h0000_0400, 32'hDEAD_BEEF, 4'b1111};
        vecs[4] = '{32'h0000_0500, 32'hFFFF_1234, 0, 1, 32'h0000_0500, 32'h1234_1234, 4'b0011};
        vecs[5] = '{32'hABCD_0600, 32'h0000_00C3, 1, 0, 32'hABCD_0600, 32'hC3C3_C3C3, 4'b0001};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_req", 32'(mem_req), 0);
        chk("reset_be", 32'(mem_be), 0);
        chk("reset_misalign", 32'(misalign), 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_ready", 32'(in_ready), 1);

        // Lane-mapping table: single store into empty buffer, head appears next cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1, vecs[i].addr, vecs[i].data, vecs[i].sb, vecs[i].sh, 0);
            step();
            drive(0, 0, 0, 0, 0, 0);
            $display("vec %0d: addr=%h data=%h sb=%0d sh=%0d -> mem_addr=%h wdata=%h be=%b",
                     i, vecs[i].addr, vecs[i].data, vecs[i].sb, vecs[i].sh, mem_addr, mem_wdata, mem_be);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 1);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
            chk($sformatf("vec%0d_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
            chk($sformatf("vec%0d_count", i), 32'(count), 1);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            chk($sformatf("vec%0d_drained", i), 32'(empty), 1);
            chk($sformatf("vec%0d_be_idle", i), 32'(mem_be), 0);
        end

        // Ack with nothing queued must be ignored.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_count", 32'(count), 0);

        // Fill / backpressure: five word stores offered with no ack.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            fill_addr[i] = 32'h0000_1000 + 32'(4 * i);
            if (in_ready) accepted++;
            drive(1, fill_addr[i], 32'hC0DE_0000 + 32'(i), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        $display("fill: offered 5, accepted %0d, count=%0d ready=%0d", accepted, count, in_ready);
        chk("fill_count", 32'(count), 4);
        chk("fill_ready", 32'(in_ready), 0);
        chk("fill_head", mem_addr, 32'h0000_1000);
        // Full with ack and valid together: pop happens, accept does not.
        drive(1, 32'h0000_2000, 32'h1111_1111, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("fullpop_count", 32'(count), 3);
        chk("fullpop_ready", 32'(in_ready), 1);
        chk("fullpop_head", mem_addr, 32'h0000_1004);
        chk("fullpop_wdata", mem_wdata, 32'hC0DE_0001);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("two_left_count", 32'(count), 2);
        // Simultaneous accept and pop at count=2.
        drive(1, 32'h0000_3000, 32'h5555_AAAA, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        $display("simul: count=%0d head=%h", count, mem_addr);
        chk("simul_count", 32'(count), 2);
        chk("simul_head", mem_addr, 32'h0000_100C);
        mem_ack = 1'b1;
        step();
        chk("order_last", mem_addr, 32'h0000_3000);
        chk("order_last_wdata", mem_wdata, 32'h5555_AAAA);
        step();
        mem_ack = 1'b0;
        chk("order_empty", 32'(empty), 1);

        // Misaligned word store.
        drive(1, 32'h0000_0302, 32'h1122_3344, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        $display("misalign: word @302 -> misalign=%0d count=%0d addr=%h be=%b",
                 misalign, count, mem_addr, mem_be);
        if (CHK) begin
            chk("mis_pulse", 32'(misalign), 1);
            chk("mis_count", 32'(count), 0);
            step();
            chk("mis_pulse_end", 32'(misalign), 0);
        end else begin
            chk("mis_tied", 32'(misalign), 0);
            chk("mis_addr", mem_addr, 32'h0000_0300);
            chk("mis_be", 32'(mem_be), 32'hF);
            chk("mis_wdata", mem_wdata, 32'h1122_3344);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end

        // Reset mid-drain discards queued entries.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_4000 + 32'(4 * i), 32'(i), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_reset_count", 32'(count), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset mid-drain: empty=%0d req=%0d be=%b", empty, mem_req, mem_be);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_be", 32'(mem_be), 0);
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        chk("rst_no_write", 32'(mem_req), 0);

        // Randomized traffic against a queue model.
        do_reset();
        q.delete();
        begin
            bit exp_mis = 1'b0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                logic v, sb, sh, ack;
                logic [31:0] ad, d;
                bit acc, pop, mis;
                chk("rnd_count", 32'(count), 32'(q.size()));
                chk("rnd_ready", 32'(in_ready), 32'(q.size() != DEPTH));
                chk("rnd_req", 32'(mem_req), 32'(q.size() != 0));
                chk("rnd_misalign", 32'(misalign), 32'(exp_mis));
                if (q.size() != 0) begin
                    chk("rnd_addr", mem_addr, q[0].addr);
                    chk("rnd_wdata", mem_wdata, q[0].wdata);
                    chk("rnd_be", 32'(mem_be), 32'(q[0].be));
                end else begin
                    chk("rnd_be_idle", 32'(mem_be), 0);
                end
                v   = ($urandom_range(0, 9) < 7);
                sb  = $urandom_range(0, 2) == 0;
                sh  = $urandom_range(0, 2) == 0;
                ad  = $urandom;
                d   = $urandom;
                ack = $urandom_range(0, 1) == 1;
                drive(v, ad, d, sb, sh, ack);
                pop = (q.size() != 0) && ack;
                acc = v && (q.size() != DEPTH);
                mis = acc && CHK && is_misaligned(ad, sb, sh);
                if (pop) void'(q.pop_front());
                if (acc && !mis) begin
                    e = fmt(ad, d, sb, sh);
                    q.push_back(e);
                    $display("rnd %0d: store addr=%h data=%h sb=%0d sh=%0d -> %h/%h/%b",
                             cyc, ad, d, sb, sh, e.addr, e.wdata, e.be);
                end
                exp_mis = mis;
                step();
            end
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
